segment_scan_driver: RTL and testbench

- Parametrised, time-multiplexed driver for an N-digit common-anode 7-segment display in the digital timer.
- Double-buffers the BCD/hex digit data and scans one digit per slot, with decimal points, optional hex glyphs, leading-zero suppression, per-digit blink and a frame tick.
- Sits between the timer counters and the board display pins.

---
 rtl/seg_pkg.sv | 22 ++
 rtl/seg_glyph_decoder.sv | 38 +++
 rtl/segment_scan_driver.sv | 142 ++++++++++++++
 tb/tb_segment_scan_driver.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared 7-segment glyph constants, active-low {dp,g,f,e,d,c,b,a} with the dp bit off.
package seg_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_A     = 8'h88;
  localparam logic [7:0] SEG_B     = 8'h83;
  localparam logic [7:0] SEG_C     = 8'hC6;
  localparam logic [7:0] SEG_D     = 8'hA1;
  localparam logic [7:0] SEG_E     = 8'h86;
  localparam logic [7:0] SEG_F     = 8'h8E;

endpackage

// File: rtl/seg_glyph_decoder.sv
// Combinational nibble-to-glyph decode; codes 10-15 blank unless hex_en is set.
module seg_glyph_decoder
  import seg_pkg::*;
(
  input  logic [3:0] code,
  input  logic       hex_en,
  output logic [6:0] seg_c
);

  logic [6:0] hex_glyph;

  always_comb begin
    seg_c     = SEG_BLANK[6:0];
    hex_glyph = SEG_BLANK[6:0];
    case (code)
      4'h0: seg_c = SEG_0[6:0];
      4'h1: seg_c = SEG_1[6:0];
      4'h2: seg_c = SEG_2[6:0];
      4'h3: seg_c = SEG_3[6:0];
      4'h4: seg_c = SEG_4[6:0];
      4'h5: seg_c = SEG_5[6:0];
      4'h6: seg_c = SEG_6[6:0];
      4'h7: seg_c = SEG_7[6:0];
      4'h8: seg_c = SEG_8[6:0];
      4'h9: seg_c = SEG_9[6:0];
      4'hA: hex_glyph = SEG_A[6:0];
      4'hB: hex_glyph = SEG_B[6:0];
      4'hC: hex_glyph = SEG_C[6:0];
      4'hD: hex_glyph = SEG_D[6:0];
      4'hE: hex_glyph = SEG_E[6:0];
      default: hex_glyph = SEG_F[6:0];
    endcase
    if (code > 4'd9) begin
      seg_c = hex_en ? hex_glyph : SEG_BLANK[6:0];
    end
  end

endmodule

// File: rtl/segment_scan_driver.sv
// Time-multiplexed common-anode 7-segment scanner with double-buffered digits,
// leading-zero suppression, per-digit blink and a frame tick.
module segment_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLINK_FRAMES = 64,
  parameter bit          HEX_EN       = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    lz_en,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [7:0]              segment_code,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic                    frame_tick
);

  localparam int unsigned DW    = 4 * NUM_DIGITS;
  localparam int unsigned CNT_W = $clog2(SCAN_DIV);
  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
  localparam int unsigned BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [BLK_W-1:0]      blk_cnt_q, blk_cnt_d;
  logic                  blink_phase_q, blink_phase_d;
  logic [DW-1:0]         pend_dig_q, pend_dig_d, act_dig_q, act_dig_d;
  logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
  logic [7:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] anode_q, anode_d;
  logic                  frame_tick_q, frame_tick_d;

  logic [3:0] cur_code_c;
  logic [6:0] glyph_c;
  logic       upper_zero_c, blink_off_c, blank_c, frame_end_c;

  seg_glyph_decoder u_glyph (
    .code   (cur_code_c),
    .hex_en (HEX_EN),
    .seg_c  (glyph_c)
  );

  // Digit under scan and whether it and every more significant digit are zero.
  always_comb begin
    cur_code_c   = act_dig_q[{idx_q, 2'b00} +: 4];
    upper_zero_c = 1'b1;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (IDX_W'(k) >= idx_q && act_dig_q[4*k +: 4] != 4'd0) begin
        upper_zero_c = 1'b0;
      end
    end
    blink_off_c = blink_mask[idx_q] & blink_phase_q;
    blank_c     = blink_off_c | (lz_en & (idx_q != '0) & upper_zero_c);
  end

  always_comb begin
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    blk_cnt_d     = blk_cnt_q;
    blink_phase_d = blink_phase_q;
    pend_dig_d    = pend_dig_q;
    pend_dp_d     = pend_dp_q;
    act_dig_d     = act_dig_q;
    act_dp_d      = act_dp_q;
    seg_d         = SEG_BLANK;
    anode_d       = '1;
    frame_tick_d  = 1'b0;
    frame_end_c   = enable && (cnt_q == CNT_LAST) && (idx_q == IDX_LAST);

    if (load) begin
      pend_dig_d = digits_in;
      pend_dp_d  = dp_in;
    end

    if (enable) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      seg_d   = {~(act_dp_q[idx_q] & ~blink_off_c), blank_c ? SEG_BLANK[6:0] : glyph_c};
      anode_d = ~(NUM_DIGITS'(1) << idx_q);
    end

    // A load coinciding with the frame boundary goes straight to the active buffer.
    if (frame_end_c) begin
      frame_tick_d = 1'b1;
      act_dig_d    = pend_dig_d;
      act_dp_d     = pend_dp_d;
      if (blk_cnt_q == BLK_LAST) begin
        blk_cnt_d     = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blk_cnt_d = blk_cnt_q + BLK_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q         <= '0;
      idx_q         <= '0;
      blk_cnt_q     <= '0;
      blink_phase_q <= 1'b0;
      pend_dig_q    <= '0;
      pend_dp_q     <= '0;
      act_dig_q     <= '0;
      act_dp_q      <= '0;
      seg_q         <= SEG_BLANK;
      anode_q       <= '1;
      frame_tick_q  <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      blk_cnt_q     <= blk_cnt_d;
      blink_phase_q <= blink_phase_d;
      pend_dig_q    <= pend_dig_d;
      pend_dp_q     <= pend_dp_d;
      act_dig_q     <= act_dig_d;
      act_dp_q      <= act_dp_d;
      seg_q         <= seg_d;
      anode_q       <= anode_d;
      frame_tick_q  <= frame_tick_d;
    end
  end

  assign segment_code = seg_q;
  assign anode        = anode_q;
  assign frame_tick   = frame_tick_q;

endmodule

// File: tb/tb_segment_scan_driver.sv
// Scoreboard bench: a cycle-count model predicts each registered output; a monitor compares.
module tb_segment_scan_driver;

  localparam int N  = 4;
  localparam int SD = 4;
  localparam int BF = 2;

  typedef struct packed {
    logic [7:0] seg_h;
    logic [7:0] seg_n;
    logic [3:0] an;
    logic       tick;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        load = 1'b0;
  logic [15:0] digits_in = '0;
  logic [3:0]  dp_in = '0;
  logic        lz_en = 1'b0;
  logic [3:0]  blink_mask = '0;
  logic [7:0]  seg_h, seg_n;
  logic [3:0]  an_h, an_n;
  logic        tick_h, tick_n;

  int tests = 0;
  int fails = 0;
  exp_t expq[$];

  // Reference model state: enabled-edge count plus the two digit buffers.
  int          e = 0;
  logic [15:0] m_pend = '0, m_act = '0;
  logic [3:0]  m_pend_dp = '0, m_act_dp = '0;

  logic [7:0] glyph_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  segment_scan_driver #(.NUM_DIGITS(N), .SCAN_DIV(SD), .BLINK_FRAMES(BF), .HEX_EN(1'b1)) u_dut_hex (
    .clk(clk), .reset(reset), .enable(enable), .load(load), .digits_in(digits_in),
    .dp_in(dp_in), .lz_en(lz_en), .blink_mask(blink_mask),
    .segment_code(seg_h), .anode(an_h), .frame_tick(tick_h)
  );

  segment_scan_driver #(.NUM_DIGITS(N), .SCAN_DIV(SD), .BLINK_FRAMES(BF), .HEX_EN(1'b0)) u_dut_nohex (
    .clk(clk), .reset(reset), .enable(enable), .load(load), .digits_in(digits_in),
    .dp_in(dp_in), .lz_en(lz_en), .blink_mask(blink_mask),
    .segment_code(seg_n), .anode(an_n), .frame_tick(tick_n)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] exp_seg(int idx, logic [15:0] act, logic [3:0] actdp, int phase,
                                         logic en, logic lz, logic [3:0] bm, bit hex);
    int         code;
    bit         blink_off, blank;
    logic [15:0] upper;
    logic [7:0] g;
    if (!en) return 8'hFF;
    upper     = act >> (4 * idx);
    code      = int'(upper & 16'h000F);
    blink_off = bm[idx] && (phase == 1);
    blank     = blink_off || (!hex && code > 9) || (lz && idx > 0 && upper == 16'h0);
    g         = blank ? 8'hFF : glyph_tab[code];
    g[7]      = ~(actdp[idx] && !blink_off);
    return g;
  endfunction

  task automatic model_reset();
    e = 0; m_pend = '0; m_act = '0; m_pend_dp = '0; m_act_dp = '0;
  endtask

  // Predict the outputs produced by the coming edge, then advance the model.
  task automatic step();
    exp_t x;
    int   idx, phase;
    idx     = (e / SD) % N;
    phase   = ((e / (SD * N)) / BF) % 2;
    x.seg_h = exp_seg(idx, m_act, m_act_dp, phase, enable, lz_en, blink_mask, 1'b1);
    x.seg_n = exp_seg(idx, m_act, m_act_dp, phase, enable, lz_en, blink_mask, 1'b0);
    x.an    = enable ? ~(4'b0001 << idx) : 4'hF;
    x.tick  = 1'b0;
    if (load) begin
      m_pend = digits_in; m_pend_dp = dp_in;
    end
    if (enable) begin
      e++;
      if (e % (SD * N) == 0) begin
        x.tick = 1'b1; m_act = m_pend; m_act_dp = m_pend_dp;
      end
    end
    @(posedge clk); #1;
    expq.push_back(x);
  endtask

  task automatic run(int n);
    repeat (n) step();
  endtask

  task automatic do_load(logic [15:0] d, logic [3:0] dp);
    load = 1'b1; digits_in = d; dp_in = dp;
    step();
    load = 1'b0;
  endtask

  task automatic check_reset_outputs(string name);
    tests++;
    if ({seg_h, an_h, tick_h, seg_n, an_n, tick_n} !== {8'hFF, 4'hF, 1'b0, 8'hFF, 4'hF, 1'b0}) begin
      fails++;
      $display("FAIL %s: got seg=%h/%h an=%h/%h tick=%b/%b, need seg=FF an=F tick=0",
               name, seg_h, seg_n, an_h, an_n, tick_h, tick_n);
    end
  endtask

  // Reset asserted between clock edges; outputs must clear without waiting for a clock.
  task automatic async_reset();
    #3 reset = 1'b1;
    #1 check_reset_outputs("async_reset");
    expq.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        x = expq.pop_front();
        tests++;
        if ({seg_h, an_h, tick_h} !== {x.seg_h, x.an, x.tick}) begin
          fails++;
          $display("FAIL hex_dut @%0t: got seg=%h an=%h tick=%b, need seg=%h an=%h tick=%b",
                   $time, seg_h, an_h, tick_h, x.seg_h, x.an, x.tick);
        end
        tests++;
        if ({seg_n, an_n, tick_n} !== {x.seg_n, x.an, x.tick}) begin
          fails++;
          $display("FAIL nohex_dut @%0t: got seg=%h an=%h tick=%b, need seg=%h an=%h tick=%b",
                   $time, seg_n, an_n, tick_n, x.seg_n, x.an, x.tick);
        end
      end
    end
  end

  initial begin : driver
    @(posedge clk); #1;
    check_reset_outputs("reset_values");
    reset = 1'b0;
    model_reset();
    enable = 1'b1;

    do_load(16'h1234, 4'b0100);
    run(40);
    lz_en = 1'b1;
    do_load(16'h0070, 4'b0000);
    run(40);
    do_load(16'h0000, 4'b0000);
    run(40);
    run(6);
    do_load(16'hABCD, 4'b0000);
    run(40);
    blink_mask = 4'b0001;
    do_load(16'h5678, 4'b1001);
    run(140);
    blink_mask = 4'b0000;
    run(5);
    enable = 1'b0;
    run(10);
    enable = 1'b1;
    run(30);
    run(7);
    async_reset();
    run(40);

    for (int i = 0; i < 2500; i++) begin
      enable = ($urandom % 10) != 0;
      load   = ($urandom % 8) == 0;
      for (int k = 0; k < 4; k++) begin
        digits_in[4*k +: 4] = ($urandom % 2 == 0) ? 4'h0 : 4'($urandom % 16);
      end
      dp_in = 4'($urandom % 16);
      if ($urandom % 64 == 0) lz_en = ~lz_en;
      if ($urandom % 128 == 0) blink_mask = 4'($urandom % 16);
      if ($urandom % 700 == 0) begin
        load = 1'b0;
        async_reset();
      end else begin
        step();
      end
    end
    load = 1'b0;
    run(3);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
